// File: rtl/imem_uart_loader.sv
// imem_uart_loader
//   Writer side of the 16-bit CPU's instruction memory. It parses load frames
//   from the UART byte stream:
//     SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, {D_H, D_L} x CNT, CHK
//   It issues one write per 16-bit word and holds the CPU while a frame is open.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   rx_data    received byte from uart_rx
//   rx_valid   1-cycle strobe qualifying rx_data
//   wr_en      instruction memory write enable (1-cycle pulse)
//   wr_addr    instruction memory write address
//   wr_data    instruction word to write
//   cpu_hold   high while a frame is in progress
//   load_done  1-cycle pulse: frame complete, checksum good
//   load_err   1-cycle pulse: checksum mismatch or inter-byte timeout
module imem_uart_loader #(
   parameter int          ADDR_W      = 12,
   parameter int          TIMEOUT_CYC = 100000,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L, S_DATA_H, S_DATA_L, S_CHK
   } state_t;

   state_t        state, state_nxt;
   logic [7:0]    hi_byte;     // high byte of the field being assembled
   logic [15:0]   remaining;   // words still to receive
   logic [7:0]    chk;         // running XOR of bytes after SYNC
   logic [TW-1:0] tmo_cnt;
   logic          timeout;
   logic [15:0]   field;

   assign field    = {hi_byte, rx_data};
   assign cpu_hold = (state != S_IDLE);

   // Fires on the cycle the counter would reach TIMEOUT_CYC; a byte arriving
   // in that same cycle takes priority and suppresses the timeout.
   assign timeout = (state != S_IDLE) && !rx_valid &&
                    (tmo_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (timeout) begin
         state_nxt = S_IDLE;
      end else if (rx_valid) begin
         case (state)
            S_IDLE:   if (rx_data == SYNC_BYTE) state_nxt = S_ADDR_H;
            S_ADDR_H: state_nxt = S_ADDR_L;
            S_ADDR_L: state_nxt = S_CNT_H;
            S_CNT_H:  state_nxt = S_CNT_L;
            S_CNT_L:  state_nxt = (field != 16'd0) ? S_DATA_H : S_CHK;
            S_DATA_H: state_nxt = S_DATA_L;
            S_DATA_L: state_nxt = (remaining == 16'd1) ? S_CHK : S_DATA_H;
            S_CHK:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         hi_byte   <= '0;
         remaining <= '0;
         chk       <= '0;
         tmo_cnt   <= '0;
      end else begin
         wr_en     <= rx_valid && (state == S_DATA_L);
         load_done <= rx_valid && (state == S_CHK) && (rx_data == chk);
         load_err  <= timeout || (rx_valid && (state == S_CHK) && (rx_data != chk));

         if (rx_valid || timeout || state == S_IDLE) tmo_cnt <= '0;
         else                                         tmo_cnt <= tmo_cnt + 1'b1;

         // Post-increment after each write; wraps naturally at 2^ADDR_W.
         // Cannot collide with the ADDR_L load because bytes are never
         // on consecutive cycles.
         if (wr_en) wr_addr <= wr_addr + 1'b1;

         if (rx_valid) begin
            case (state)
               S_IDLE: chk <= '0;
               S_ADDR_H, S_CNT_H, S_DATA_H: begin
                  hi_byte <= rx_data;
                  chk     <= chk ^ rx_data;
               end
               S_ADDR_L: begin
                  wr_addr <= field[ADDR_W-1:0];
                  chk     <= chk ^ rx_data;
               end
               S_CNT_L: begin
                  remaining <= field;
                  chk       <= chk ^ rx_data;
               end
               S_DATA_L: begin
                  wr_data   <= field;
                  remaining <= remaining - 1'b1;
                  chk       <= chk ^ rx_data;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
